// File: rtl/riscv_defines.sv
// Shared RV32M multiply/divide opcodes and MDU state encoding, also used by the controller.
package riscv_defines;

  localparam int MDU_OP_WIDTH = 3;

  // Encoded exactly as the RV32M funct3 field so the controller can pass it straight through
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'b000;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'b001;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'b010;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'b011;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'b100;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'b101;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'b110;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_PREP,
    MDU_CALC,
    MDU_DONE
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_prep.sv
// Operand conditioning for the MDU: unsigned magnitudes, result sign and division special cases.
module mdu_sign_prep
  import riscv_defines::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [MDU_OP_WIDTH-1:0] mdu_op,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic [DATA_WIDTH-1:0]   mag_a,
  output logic [DATA_WIDTH-1:0]   mag_b,
  output logic                    neg_result,
  output logic                    div_zero,
  output logic                    div_ovf
);

  logic signed_a;
  logic signed_b;
  logic sign_a;
  logic sign_b;
  logic is_rem;

  assign signed_a = (mdu_op == MDU_MULH) || (mdu_op == MDU_MULHSU) ||
                    (mdu_op == MDU_DIV)  || (mdu_op == MDU_REM);
  assign signed_b = (mdu_op == MDU_MULH) || (mdu_op == MDU_DIV) || (mdu_op == MDU_REM);

  assign sign_a = signed_a & op_a[DATA_WIDTH-1];
  assign sign_b = signed_b & op_b[DATA_WIDTH-1];

  // Negating the most-negative value yields itself, which is the correct unsigned magnitude
  assign mag_a = sign_a ? -op_a : op_a;
  assign mag_b = sign_b ? -op_b : op_b;

  // A remainder always takes the sign of the dividend
  assign is_rem     = (mdu_op == MDU_REM) || (mdu_op == MDU_REMU);
  assign neg_result = is_rem ? sign_a : (sign_a ^ sign_b);

  assign div_zero = (op_b == '0);
  assign div_ovf  = signed_b && mdu_op[2] &&
                    (op_a == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (op_b == '1);

endmodule

// File: rtl/mult_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply or restoring divide, fixed latency.
module mult_div_unit
  import riscv_defines::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    flush_i,
  input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
  input  logic [DATA_WIDTH-1:0]   op_a_i,
  input  logic [DATA_WIDTH-1:0]   op_b_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DATA_WIDTH-1:0]   result_o
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);

  mdu_state_e                state_q, state_d;
  logic [MDU_OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0]     a_q, b_q;
  logic [DATA_WIDTH-1:0]     mag_a_q, mag_b_q;
  logic                      neg_q, div_zero_q, div_ovf_q;
  logic [2*DATA_WIDTH-1:0]   acc_q, acc_step;
  logic [CNT_WIDTH-1:0]      cnt_q;

  logic [DATA_WIDTH-1:0]     prep_mag_a, prep_mag_b;
  logic                      prep_neg, prep_div_zero, prep_div_ovf;

  logic [DATA_WIDTH:0]       mul_sum;
  logic [DATA_WIDTH:0]       div_part;
  logic [DATA_WIDTH+1:0]     div_trial;
  logic [2*DATA_WIDTH-1:0]   prod_fix;
  logic [DATA_WIDTH-1:0]     div_val, div_fix, result_d;
  logic                      accept;

  mdu_sign_prep #(.DATA_WIDTH(DATA_WIDTH)) u_sign_prep (
    .mdu_op     (op_q),
    .op_a       (a_q),
    .op_b       (b_q),
    .mag_a      (prep_mag_a),
    .mag_b      (prep_mag_b),
    .neg_result (prep_neg),
    .div_zero   (prep_div_zero),
    .div_ovf    (prep_div_ovf)
  );

  assign accept = (state_q == MDU_IDLE) && start_i && !flush_i;
  assign busy_o = (state_q != MDU_IDLE);
  assign done_o = (state_q == MDU_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (accept) state_d = MDU_PREP;
      MDU_PREP: state_d = MDU_CALC;
      MDU_CALC: if (cnt_q == '0) state_d = MDU_DONE;
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    if (flush_i && (state_q != MDU_IDLE)) state_d = MDU_IDLE;
  end

  // One iteration: multiply adds into the upper half then shifts right; divide shifts left
  // and keeps the trial subtraction when it does not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    div_part  = acc_q[2*DATA_WIDTH-1:DATA_WIDTH-1];
    div_trial = {1'b0, div_part} - {2'b00, mag_b_q};
    if (op_q[2]) begin
      if (!div_trial[DATA_WIDTH+1])
        acc_step = {div_trial[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b1};
      else
        acc_step = {div_part[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[DATA_WIDTH-1:1]};
    end
  end

  // Result is formed from the final iteration so it is already registered in DONE
  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    div_val  = op_q[1] ? acc_step[2*DATA_WIDTH-1:DATA_WIDTH] : acc_step[DATA_WIDTH-1:0];
    div_fix  = neg_q ? -div_val : div_val;
    result_d = div_fix;
    if (!op_q[2]) begin
      result_d = (op_q[1:0] == 2'b00) ? prod_fix[DATA_WIDTH-1:0]
                                      : prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
    end else if (div_zero_q) begin
      result_d = op_q[1] ? a_q : '1;
    end else if (div_ovf_q) begin
      result_d = op_q[1] ? '0 : a_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= MDU_IDLE;
      op_q       <= MDU_MUL;
      a_q        <= '0;
      b_q        <= '0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_o   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        MDU_IDLE: begin
          if (accept) begin
            op_q <= mdu_op_i;
            a_q  <= op_a_i;
            b_q  <= op_b_i;
          end
        end
        MDU_PREP: begin
          mag_a_q    <= prep_mag_a;
          mag_b_q    <= prep_mag_b;
          neg_q      <= prep_neg;
          div_zero_q <= prep_div_zero;
          div_ovf_q  <= prep_div_ovf;
          cnt_q      <= CNT_WIDTH'(DATA_WIDTH - 1);
          // Upper half cleared; low half seeded with the multiplier or the dividend
          acc_q      <= op_q[2] ? {{DATA_WIDTH{1'b0}}, prep_mag_a}
                                : {{DATA_WIDTH{1'b0}}, prep_mag_b};
        end
        MDU_CALC: begin
          acc_q <= acc_step;
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_WIDTH'(1);
          if ((cnt_q == '0) && !flush_i) result_o <= result_d;
        end
        default: ;
      endcase
    end
  end

endmodule
